// File: rtl/fs_ack_responder.sv
// Fs transfer responder: acks Dt requests and assembles 2-bit symbols
// into a frame, then holds senack until the sequencer clears it.
module fs_ack_responder #(
    parameter  int FRAME_LEN = 4,
    parameter  int ACK_DELAY = 2,
    localparam int FW        = 2 * FRAME_LEN,
    localparam int CW        = $clog2(FRAME_LEN) + 1,
    localparam int DW        = $clog2(ACK_DELAY + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Dt,
    input  logic          bit0,
    input  logic          bit1,
    input  logic          cclear,
    output logic          ack,
    output logic          senack,
    output logic [FW-1:0] frame_data,
    output logic [CW-1:0] xfer_count,
    output logic          abort,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_SEND = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          ack_q, ack_d;
    logic          senack_q, senack_d;
    logic          abort_q, abort_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CW'(1);

    // Next-state and registered-output decode; cclear overrides everything.
    always_comb begin
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        ack_d    = ack_q;
        senack_d = senack_q;
        abort_d  = 1'b0;
        frame_d  = frame_q;
        cnt_d    = cnt_q;
        if (cclear) begin
            state_d  = S_IDLE;
            dcnt_d   = '0;
            ack_d    = 1'b0;
            senack_d = 1'b0;
            frame_d  = '0;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (Dt) begin
                        state_d = S_WAIT;
                        dcnt_d  = DW'(1);
                    end
                end
                S_WAIT: begin
                    if (!Dt) begin
                        state_d = S_IDLE;
                        abort_d = 1'b1;
                        dcnt_d  = '0;
                    end else if (dcnt_q == DW'(ACK_DELAY)) begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                        dcnt_d  = '0;
                        frame_d = {frame_q[FW-3:0], bit1, bit0};
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end
                S_ACK: begin
                    if (!Dt) begin
                        ack_d = 1'b0;
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(FRAME_LEN)) begin
                            state_d  = S_SEND;
                            senack_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_SEND: begin
                    senack_d = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            dcnt_q   <= '0;
            ack_q    <= 1'b0;
            senack_q <= 1'b0;
            abort_q  <= 1'b0;
            frame_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            ack_q    <= ack_d;
            senack_q <= senack_d;
            abort_q  <= abort_d;
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ack        = ack_q;
    assign senack     = senack_q;
    assign abort      = abort_q;
    assign frame_data = frame_q;
    assign xfer_count = cnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_fs_ack_responder.sv
// Directed bench for fs_ack_responder with an expectation queue.
module tb_fs_ack_responder;

    logic       clk;
    logic       reset;
    logic       Dt;
    logic       bit0;
    logic       bit1;
    logic       cclear;
    logic       ack;
    logic       senack;
    logic [7:0] frame_data;
    logic [2:0] xfer_count;
    logic       abort;
    logic [1:0] state;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    fs_ack_responder #(.FRAME_LEN(4), .ACK_DELAY(2)) dut (
        .clk(clk),
        .reset(reset),
        .Dt(Dt),
        .bit0(bit0),
        .bit1(bit1),
        .cclear(cclear),
        .ack(ack),
        .senack(senack),
        .frame_data(frame_data),
        .xfer_count(xfer_count),
        .abort(abort),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expv(input string t, input logic [31:0] v);
        sb.push_back('{t, v});
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=%0h required=entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h required=%0h",
                       e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [1:0] sym, input string t);
        Dt   = 1'b1;
        bit1 = sym[1];
        bit0 = sym[0];
        step();
        step();
        expv({t, "_ack_pre"}, 32'd0);
        chk(32'(ack));
        step();
        expv({t, "_ack"}, 32'd1);
        chk(32'(ack));
        Dt = 1'b0;
        step();
        expv({t, "_ack_drop"}, 32'd0);
        chk(32'(ack));
    endtask

    task automatic clear();
        cclear = 1'b1;
        step();
        cclear = 1'b0;
    endtask

    initial begin
        reset  = 1'b0;
        Dt     = 1'b0;
        bit0   = 1'b0;
        bit1   = 1'b0;
        cclear = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();

        expv("rst_state", 32'd0);  chk(32'(state));
        expv("rst_ack", 32'd0);    chk(32'(ack));
        expv("rst_senack", 32'd0); chk(32'(senack));
        expv("rst_abort", 32'd0);  chk(32'(abort));
        expv("rst_frame", 32'd0);  chk(32'(frame_data));
        expv("rst_cnt", 32'd0);    chk(32'(xfer_count));

        // single transfer, symbol 10
        Dt   = 1'b1;
        bit1 = 1'b1;
        bit0 = 1'b0;
        step();
        expv("t1_wait", 32'd1); chk(32'(state));
        step();
        expv("t1_ack_e1", 32'd0); chk(32'(ack));
        step();
        expv("t1_ack_e2", 32'd1);  chk(32'(ack));
        expv("t1_state", 32'd2);   chk(32'(state));
        expv("t1_sym", 32'd2);     chk(32'(frame_data[1:0]));
        Dt = 1'b0;
        step();
        expv("t1_ack_off", 32'd0); chk(32'(ack));
        expv("t1_cnt", 32'd1);     chk(32'(xfer_count));
        expv("t1_idle", 32'd0);    chk(32'(state));

        // full frame
        clear();
        expv("clr_cnt", 32'd0); chk(32'(xfer_count));
        xfer(2'b11, "f0");
        xfer(2'b01, "f1");
        xfer(2'b10, "f2");
        xfer(2'b00, "f3");
        expv("fr_data", 32'hD8);  chk(32'(frame_data));
        expv("fr_senack", 32'd1); chk(32'(senack));
        expv("fr_state", 32'd3);  chk(32'(state));
        expv("fr_cnt", 32'd4);    chk(32'(xfer_count));

        // backpressure in SEND
        Dt   = 1'b1;
        bit1 = 1'b1;
        bit0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            expv("bp_ack", 32'd0); chk(32'(ack));
        end
        expv("bp_frame", 32'hD8); chk(32'(frame_data));
        Dt = 1'b0;
        clear();
        expv("cc_senack", 32'd0); chk(32'(senack));
        expv("cc_cnt", 32'd0);    chk(32'(xfer_count));
        expv("cc_frame", 32'd0);  chk(32'(frame_data));
        expv("cc_state", 32'd0);  chk(32'(state));

        // abort before ACK_DELAY
        xfer(2'b01, "ab_pre");
        Dt = 1'b1;
        step();
        Dt = 1'b0;
        step();
        expv("ab_pulse", 32'd1); chk(32'(abort));
        expv("ab_idle", 32'd0);  chk(32'(state));
        expv("ab_ack", 32'd0);   chk(32'(ack));
        step();
        expv("ab_end", 32'd0);   chk(32'(abort));
        expv("ab_cnt", 32'd1);   chk(32'(xfer_count));
        expv("ab_frame", 32'd1); chk(32'(frame_data));

        // abort and cclear together
        Dt = 1'b1;
        step();
        Dt     = 1'b0;
        cclear = 1'b1;
        step();
        cclear = 1'b0;
        expv("abcc_abort", 32'd0); chk(32'(abort));
        expv("abcc_cnt", 32'd0);   chk(32'(xfer_count));

        // asynchronous reset while ack is high
        xfer(2'b10, "rs0");
        Dt   = 1'b1;
        bit1 = 1'b0;
        bit0 = 1'b1;
        step();
        step();
        step();
        expv("rs_ack_hi", 32'd1); chk(32'(ack));
        #2 reset = 1'b0;
        #1;
        expv("rs_ack_lo", 32'd0); chk(32'(ack));
        expv("rs_cnt", 32'd0);    chk(32'(xfer_count));
        expv("rs_frame", 32'd0);  chk(32'(frame_data));
        Dt = 1'b0;
        step();
        reset = 1'b1;
        step();
        xfer(2'b11, "rs1");
        expv("rs_new_cnt", 32'd1); chk(32'(xfer_count));

        // cclear in ACK with Dt held high
        Dt = 1'b1;
        step();
        step();
        step();
        expv("ca_ack", 32'd1); chk(32'(ack));
        cclear = 1'b1;
        step();
        cclear = 1'b0;
        expv("ca_ack_lo", 32'd0); chk(32'(ack));
        expv("ca_idle", 32'd0);   chk(32'(state));
        step();
        expv("ca_wait", 32'd1);   chk(32'(state));
        step();
        expv("ca_ack_e1", 32'd0); chk(32'(ack));
        step();
        expv("ca_ack_re", 32'd1); chk(32'(ack));
        Dt = 1'b0;
        step();
        expv("ca_cnt", 32'd1);    chk(32'(xfer_count));

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL sb_leftover observed=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
